// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default sizing constants for the multiport register file
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;
  localparam int ZERO_IDX = 0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one read port: register mux, write bypass, output registers
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rnum,
  input  logic [DATA_W-1:0]     regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]  pending_nxt,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wnum,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  rbusy
);

  logic [DATA_W-1:0] data_d;

  // wr_en already excludes the zero register, so the explicit zero only guards the array value
  always_comb begin
    data_d = regs[rnum];
    if (wr_en && (wnum == rnum))
      data_d = wdata;
    if ((ZERO_REG != 0) && (rnum == ADDR_W'(ZERO_IDX)))
      data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      rbusy  <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= data_d;
        rbusy <= pending_nxt[rnum];
      end
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-read-port register file with pending-producer scoreboard
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_RD   = regfile_pkg::NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rnum,
  input  logic [NUM_RD-1:0]        rd_en,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        wnum,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     lock,
  input  logic [ADDR_W-1:0]        lnum
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic              wr_en;
  logic              lock_en;

  assign wr_en   = write && !((ZERO_REG != 0) && (wnum == ADDR_W'(ZERO_IDX)));
  assign lock_en = lock  && !((ZERO_REG != 0) && (lnum == ADDR_W'(ZERO_IDX)));

  // set after clear so a same-cycle lock keeps the register pending
  always_comb begin
    pending_nxt = pending;
    if (write)
      pending_nxt[wnum] = 1'b0;
    if (lock_en)
      pending_nxt[lnum] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wr_en)
        regs[wnum] <= wdata;
      pending <= pending_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en[k]),
      .rnum        (rnum[k*ADDR_W +: ADDR_W]),
      .regs        (regs),
      .pending_nxt (pending_nxt),
      .wr_en       (wr_en),
      .wnum        (wnum),
      .wdata       (wdata),
      .rdata       (rdata[k*DATA_W +: DATA_W]),
      .rvalid      (rvalid[k]),
      .rbusy       (rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard bench for regfile_multiport, ZERO_REG=1 and ZERO_REG=0 side by side
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rnum;
  logic [1:0]  rd_en;
  logic        write;
  logic [4:0]  wnum;
  logic [31:0] wdata;
  logic        lock;
  logic [4:0]  lnum;

  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rvalid_a, rvalid_b, rbusy_a, rbusy_b;

  always #5 clk = ~clk;

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .rst(rst), .rnum(rnum), .rd_en(rd_en), .rdata(rdata_a), .rvalid(rvalid_a),
    .rbusy(rbusy_a), .write(write), .wnum(wnum), .wdata(wdata), .lock(lock), .lnum(lnum)
  );

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst(rst), .rnum(rnum), .rd_en(rd_en), .rdata(rdata_b), .rvalid(rvalid_b),
    .rbusy(rbusy_b), .write(write), .wnum(wnum), .wdata(wdata), .lock(lock), .lnum(lnum)
  );

  typedef struct {
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t        exp_q [4][$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] rd_m [2];
  logic [1:0]  rv_m [2];
  logic [1:0]  rb_m [2];

  assign rd_m[0] = rdata_a;
  assign rd_m[1] = rdata_b;
  assign rv_m[0] = rvalid_a;
  assign rv_m[1] = rvalid_b;
  assign rb_m[0] = rbusy_a;
  assign rb_m[1] = rbusy_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // d: 0 = ZERO_REG=1 instance, 1 = ZERO_REG=0 instance
  task automatic push(input int d, input int k, input logic [31:0] data, input logic busy);
    exp_t e;
    e.data = data;
    e.busy = busy;
    exp_q[d*2+k].push_back(e);
  endtask

  task automatic push2(input int k, input logic [31:0] data, input logic busy);
    push(0, k, data, busy);
    push(1, k, data, busy);
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] wn, input logic [31:0] wd,
                      input logic lk, input logic [4:0] ln, input logic [1:0] en,
                      input logic [4:0] n0, input logic [4:0] n1);
    rst   = r;
    write = w;
    wnum  = wn;
    wdata = wd;
    lock  = lk;
    lnum  = ln;
    rd_en = en;
    rnum  = {n1, n0};
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        if (rv_m[d][k] === 1'b1) begin
          if (exp_q[d*2+k].size() == 0) begin
            chk($sformatf("dut%0d port%0d unexpected rvalid", d, k), 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = exp_q[d*2+k].pop_front();
            chk($sformatf("dut%0d port%0d rdata", d, k), {32'd0, rd_m[d][k*32 +: 32]}, {32'd0, e.data});
            chk($sformatf("dut%0d port%0d rbusy", d, k), {63'd0, rb_m[d][k]}, {63'd0, e.busy});
          end
        end
      end
    end
  end

  initial begin
    step(1, 1, 5'd4, 32'h1111_1111, 1, 5'd4, 2'b11, 5'd4, 5'd4);
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 2'b00, 5'd0, 5'd0);
    chk("reset rvalid a", {62'd0, rvalid_a}, 64'd0);
    chk("reset rdata a", rdata_a, 64'd0);
    chk("reset rbusy b", {62'd0, rbusy_b}, 64'd0);

    // first read after reset: write issued during reset must not have landed
    push2(0, 32'h0, 1'b0);
    push2(1, 32'h0, 1'b0);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b11, 5'd4, 5'd5);

    step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 2'b00, 5'd0, 5'd0);
    push2(0, 32'hDEAD_BEEF, 1'b0);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b01, 5'd5, 5'd0);

    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b00, 5'd7, 5'd7);
    chk("hold rdata0", {32'd0, rdata_a[31:0]}, 64'hDEAD_BEEF);
    chk("idle rvalid", {62'd0, rvalid_b}, 64'd0);

    push2(0, 32'h1234_5678, 1'b0);
    push2(1, 32'h1234_5678, 1'b0);
    step(0, 1, 5'd7, 32'h1234_5678, 0, 5'd0, 2'b11, 5'd7, 5'd7);

    push(0, 1, 32'h0, 1'b0);
    push(1, 1, 32'hFFFF_FFFF, 1'b0);
    step(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 2'b10, 5'd0, 5'd0);
    step(0, 0, 5'd0, 32'h0, 1, 5'd0, 2'b00, 5'd0, 5'd0);
    push(0, 0, 32'h0, 1'b0);
    push(1, 0, 32'hFFFF_FFFF, 1'b1);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b01, 5'd0, 5'd0);

    step(0, 0, 5'd0, 32'h0, 1, 5'd3, 2'b00, 5'd0, 5'd0);
    push2(0, 32'h0, 1'b1);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b01, 5'd3, 5'd0);
    push2(0, 32'hA5A5_A5A5, 1'b0);
    push2(1, 32'hA5A5_A5A5, 1'b0);
    step(0, 1, 5'd3, 32'hA5A5_A5A5, 0, 5'd0, 2'b11, 5'd3, 5'd3);
    push2(0, 32'h0, 1'b1);
    step(0, 0, 5'd0, 32'h0, 1, 5'd4, 2'b01, 5'd4, 5'd0);

    step(0, 1, 5'd9, 32'h0000_0099, 1, 5'd9, 2'b00, 5'd0, 5'd0);
    push2(0, 32'h0000_0099, 1'b1);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b01, 5'd9, 5'd0);

    for (int i = 1; i < 32; i++)
      step(0, 1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 2'b00, 5'd0, 5'd0);
    push2(0, 32'h0000_011F, 1'b0);
    push2(1, 32'h0000_0101, 1'b0);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b11, 5'd31, 5'd1);

    step(1, 1, 5'd2, 32'h0000_0BAD, 1, 5'd2, 2'b11, 5'd2, 5'd9);
    chk("post-reset rvalid a", {62'd0, rvalid_a}, 64'd0);
    chk("post-reset rdata b", rdata_b, 64'd0);
    chk("post-reset rbusy a", {62'd0, rbusy_a}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      push2(0, 32'h0, 1'b0);
      push2(1, 32'h0, 1'b0);
      step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b11, 5'(i), 5'(31 - i));
    end

    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b00, 5'd0, 5'd0);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 2'b00, 5'd0, 5'd0);
    for (int q = 0; q < 4; q++)
      chk($sformatf("queue %0d drained", q), 64'(exp_q[q].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
